// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant held until the owner releases.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  // state | meaning
  // IDLE  | no grant outstanding; arbitrate on any request
  // BUSY  | grant held by gnt_idx until done, req drop or timeout
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam int SUM_W = IDX_W + 1;

  if (N < 2 || N > (2 ** IDX_W) || MAX_HOLD < 1) begin : g_bad_param
    $error("rr_arbiter: illegal parameter combination");
  end

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     gnt_q;

  // Rotate the request vector so bit 0 is the requester at ptr.
  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] offset;
  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] winner;
  logic [N-1:0]     winner_oh;
  logic             found;

  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N-1:0];
    offset  = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        offset = IDX_W'(k);
        found  = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= SUM_W'(N)) begin
      sum = sum - SUM_W'(N);
    end
    winner    = sum[IDX_W-1:0];
    winner_oh = {{(N-1){1'b0}}, 1'b1} << winner;
  end

  logic             owner_req;
  logic             release_now;
  logic             force_rel;
  logic [IDX_W-1:0] ptr_next;

  assign owner_req   = |(req & gnt_q);
  assign release_now = done | ~owner_req;
  assign ptr_next    = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  // Down-counter loaded on grant; terminal count means MAX_HOLD cycles elapsed.
  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_q;

  assign force_rel = (state == S_BUSY) && !release_now && (hold_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_rel;
      if (state == S_IDLE) begin
        hold_cnt <= HOLD_W'(MAX_HOLD - 1);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      idx_q <= '0;
      gnt_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            state <= S_BUSY;
            idx_q <= winner;
            gnt_q <= winner_oh;
          end
        end
        S_BUSY: begin
          // No new grant in the release cycle: always one bubble before the next.
          if (release_now || force_rel) begin
            state <= S_IDLE;
            ptr   <= ptr_next;
            idx_q <= '0;
            gnt_q <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          idx_q <= '0;
          gnt_q <= '0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state == S_BUSY);

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios plus random traffic against a
// behavioural model (owner/pointer kept as plain integers).
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int IDX_W    = 2;
  localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  int total = 0;
  int bad   = 0;

  // model state: m_owner < 0 means idle
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  rr_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input logic [N-1:0] rq, input bit d);
    bit rel;
    bit frc;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && rq[c]) m_owner = c;
      end
      m_hold = 0;
    end else begin
      rel = d || !rq[m_owner];
      frc = TO_EN && !rel && (m_hold == MAX_HOLD - 1);
      if (rel || frc) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_to    = frc;
      end else begin
        m_hold++;
        m_to = 1'b0;
      end
    end
  endtask

  task automatic step(input bit r, input logic [N-1:0] rq, input bit d);
    rst  = r;
    req  = rq;
    done = d;
    @(posedge clk);
    model_edge(r, rq, d);
    #1;
    chk("gnt",       32'(gnt),       (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    chk("gnt_idx",   32'(gnt_idx),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("timeout",   32'(timeout),   32'(m_to));
  endtask

  initial begin
    logic [N-1:0] rq;
    rst = 1'b1; req = '0; done = 1'b0;

    // reset with all requests active
    step(1, 4'b1111, 0);
    step(1, 4'b1111, 0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    step(0, 4'b0000, 0);

    // single request, done release, successor search from ptr=3
    step(0, 4'b0100, 0);
    chk("t2_gnt", 32'(gnt), 32'h4);
    chk("t2_idx", 32'(gnt_idx), 32'd2);
    step(0, 4'b0100, 0);
    step(0, 4'b0100, 1);
    chk("t2_rel", 32'(gnt_valid), 32'd0);
    step(0, 4'b0101, 0);
    chk("t2_next", 32'(gnt_idx), 32'd0);
    step(0, 4'b0000, 0);

    // all requesting, done every busy cycle: 0,1,2,3,0
    step(1, 4'b0000, 0);
    for (int g = 0; g < 5; g++) begin
      step(0, 4'b1111, 0);
      chk("t3_seq", 32'(gnt_idx), 32'(g % N));
      step(0, 4'b1111, 1);
    end

    // non-owner request changes ignored while busy on idx 1
    step(0, 4'b0010, 0);
    chk("t4_own", 32'(gnt), 32'h2);
    step(0, 4'b1011, 0);
    step(0, 4'b1011, 0);
    chk("t4_hold", 32'(gnt), 32'h2);
    step(0, 4'b1011, 1);
    step(0, 4'b1011, 0);
    chk("t4_next", 32'(gnt_idx), 32'd3);
    step(0, 4'b0000, 0);

    // release by req drop, then reset mid-grant
    step(0, 4'b0100, 0);
    step(0, 4'b0000, 0);
    step(0, 4'b1001, 0);
    chk("t5_ptr3", 32'(gnt_idx), 32'd3);
    step(1, 4'b1001, 0);
    chk("t5_rst", 32'(gnt), 32'd0);
    step(0, 4'b1001, 0);
    chk("t5_ptr0", 32'(gnt_idx), 32'd0);
    step(0, 4'b0000, 0);

    // long hold (forced release only when timeout is built in)
    for (int i = 0; i < 2 * MAX_HOLD + 4; i++) step(0, 4'b0001, 0);
    step(0, 4'b0000, 0);

    // random traffic
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom_range(0, (1 << N) - 1));
      step(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
